// File: rtl/mcp3008_spi_responder_if.sv
// SPI link between an MCP3008-style master and the responder emulator.
interface mcp3008_spi_responder_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output cs_n, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input cs_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/mcp3008_spi_responder.sv
// MCP3008 ADC emulator: decodes the SPI command frame, computes the single-ended or
// clamped differential result from parallel channel words and shifts it out on miso.
module mcp3008_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int LSB_TAIL    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  mcp3008_spi_responder_if.slave   spi,
  input  logic [79:0]              ch_data,
  output logic                     conv_valid,
  output logic                     conv_sgl,
  output logic [2:0]               conv_ch,
  output logic [9:0]               conv_result,
  output logic [7:0]               abort_cnt
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    CMD        = 3'd2,
    SAMPLE     = 3'd3,
    NULL_OUT   = 3'd4,
    DATA_MSB   = 3'd5,
    TAIL       = 3'd6
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  state_e      state_q, state_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [2:0]  cmd_q, cmd_d;
  logic        miso_q, miso_d;
  logic        miso_oe_q, miso_oe_d;
  logic        conv_valid_q, conv_valid_d;
  logic        conv_sgl_q, conv_sgl_d;
  logic [2:0]  conv_ch_q, conv_ch_d;
  logic [9:0]  conv_result_q, conv_result_d;
  logic [7:0]  abort_cnt_q, abort_cnt_d;

  logic        sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s, mosi_s, mid_frame_s;
  logic [9:0]  ch_arr_s [8];
  logic [9:0]  pos_s, neg_s, result_s;
  logic [10:0] diff_s;

  // Channel unpacking and result arithmetic; D0 is the bit arriving on this sclk rise.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      ch_arr_s[i] = ch_data[i*10 +: 10];
    end
    pos_s    = ch_arr_s[{cmd_q[1:0], mosi_s}];
    neg_s    = ch_arr_s[{cmd_q[1:0], ~mosi_s}];
    diff_s   = {1'b0, pos_s} - {1'b0, neg_s};
    if (cmd_q[2]) begin
      result_s = pos_s;
    end else if (diff_s[10]) begin
      result_s = 10'd0;
    end else begin
      result_s = diff_s[9:0];
    end
  end

  // Synchronizers, edge detection and the protocol state machine next-state logic.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi.cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
    sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
    cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
    sclk_rise_s = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    sclk_fall_s = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
    cs_rise_s   = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
    cs_fall_s   = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    mid_frame_s = (state_q == CMD) || (state_q == SAMPLE) ||
                  (state_q == NULL_OUT) || (state_q == DATA_MSB);

    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    cmd_d         = cmd_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    conv_valid_d  = 1'b0;
    conv_sgl_d    = conv_sgl_q;
    conv_ch_d     = conv_ch_q;
    conv_result_d = conv_result_q;
    abort_cnt_d   = abort_cnt_q;

    // A cs_n rise pre-empts any sclk edge seen in the same cycle.
    if (cs_rise_s) begin
      state_d   = IDLE;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      bit_idx_d = 4'd0;
      if (mid_frame_s && (abort_cnt_q != 8'hFF)) begin
        abort_cnt_d = abort_cnt_q + 8'd1;
      end else begin
        abort_cnt_d = abort_cnt_q;
      end
    end else begin
      case (state_q)
        IDLE: begin
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
          if (cs_fall_s) begin
            state_d = WAIT_START;
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_START: begin
          if (sclk_rise_s && mosi_s) begin
            state_d   = CMD;
            bit_idx_d = 4'd0;
          end else begin
            state_d = WAIT_START;
          end
        end
        CMD: begin
          if (sclk_rise_s && (bit_idx_q == 4'd3)) begin
            conv_sgl_d    = cmd_q[2];
            conv_ch_d     = {cmd_q[1:0], mosi_s};
            conv_result_d = result_s;
            conv_valid_d  = 1'b1;
            bit_idx_d     = 4'd0;
            state_d       = SAMPLE;
          end else if (sclk_rise_s) begin
            cmd_d     = {cmd_q[1:0], mosi_s};
            bit_idx_d = bit_idx_q + 4'd1;
          end else begin
            state_d = CMD;
          end
        end
        SAMPLE: begin
          if (sclk_rise_s) begin
            state_d = NULL_OUT;
          end else begin
            state_d = SAMPLE;
          end
        end
        NULL_OUT: begin
          if (sclk_fall_s) begin
            miso_d    = 1'b0;
            miso_oe_d = 1'b1;
            bit_idx_d = 4'd9;
            state_d   = DATA_MSB;
          end else begin
            state_d = NULL_OUT;
          end
        end
        DATA_MSB: begin
          if (sclk_fall_s && (bit_idx_q == 4'd0)) begin
            miso_d    = conv_result_q[0];
            bit_idx_d = 4'd1;
            state_d   = TAIL;
          end else if (sclk_fall_s) begin
            miso_d    = conv_result_q[bit_idx_q];
            bit_idx_d = bit_idx_q - 4'd1;
          end else begin
            state_d = DATA_MSB;
          end
        end
        TAIL: begin
          if (sclk_fall_s && (LSB_TAIL != 0) && (bit_idx_q <= 4'd9)) begin
            miso_d    = conv_result_q[bit_idx_q];
            bit_idx_d = bit_idx_q + 4'd1;
          end else if (sclk_fall_s) begin
            miso_d = 1'b0;
          end else begin
            state_d = TAIL;
          end
        end
        default: begin
          state_d   = IDLE;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
          bit_idx_d = 4'd0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset; synchronizers reset to idle bus levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b1;
      state_q       <= IDLE;
      bit_idx_q     <= 4'd0;
      cmd_q         <= 3'd0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      conv_valid_q  <= 1'b0;
      conv_sgl_q    <= 1'b0;
      conv_ch_q     <= 3'd0;
      conv_result_q <= 10'd0;
      abort_cnt_q   <= 8'd0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      cs_prev_q     <= cs_prev_d;
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      cmd_q         <= cmd_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      conv_valid_q  <= conv_valid_d;
      conv_sgl_q    <= conv_sgl_d;
      conv_ch_q     <= conv_ch_d;
      conv_result_q <= conv_result_d;
      abort_cnt_q   <= abort_cnt_d;
    end
  end

  assign spi.miso    = miso_q;
  assign spi.miso_oe = miso_oe_q;
  assign conv_valid  = conv_valid_q;
  assign conv_sgl    = conv_sgl_q;
  assign conv_ch     = conv_ch_q;
  assign conv_result = conv_result_q;
  assign abort_cnt   = abort_cnt_q;

endmodule

// File: tb/tb_mcp3008_spi_responder.sv
// Directed bench for the MCP3008 responder: a mode-0 SPI master at clk/10 with
// hand-computed expected words, checked by immediate assertions.
module tb_mcp3008_spi_responder;
  localparam int SYNC = 2;

  logic        clk;
  logic        rst;
  logic [79:0] ch_data;
  logic        conv_valid;
  logic        conv_sgl;
  logic [2:0]  conv_ch;
  logic [9:0]  conv_result;
  logic [7:0]  abort_cnt;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int valid_cnt = 0;

  mcp3008_spi_responder_if spi_i ();

  mcp3008_spi_responder #(.SYNC_STAGES(SYNC), .LSB_TAIL(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi         (spi_i),
    .ch_data     (ch_data),
    .conv_valid  (conv_valid),
    .conv_sgl    (conv_sgl),
    .conv_ch     (conv_ch),
    .conv_result (conv_result),
    .abort_cnt   (abort_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (conv_valid === 1'b1) valid_cnt++;
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int n, input logic [9:0] v);
    ch_data[n*10 +: 10] = v;
  endtask

  // One sclk period: mosi set while low, miso/miso_oe sampled as sclk rises.
  task automatic spi_bit(input logic mo, output logic mi, output logic oe);
    spi_i.mosi = mo;
    repeat (5) @(negedge clk);
    spi_i.sclk = 1'b1;
    mi = spi_i.miso;
    oe = spi_i.miso_oe;
    repeat (5) @(negedge clk);
    spi_i.sclk = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] oe);
    logic mi, o;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], mi, o);
      rx[i] = mi;
      oe[i] = o;
    end
  endtask

  task automatic cs_low();
    spi_i.cs_n = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (5) @(negedge clk);
    spi_i.cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  logic [7:0] rx1, rx2, rx3, rx4, rx5;
  logic [7:0] oe1, oe2, oe3, oe4, oe5;
  logic       mi, oe;
  int         v0;

  initial begin
    spi_i.sclk = 1'b0;
    spi_i.cs_n = 1'b1;
    spi_i.mosi = 1'b0;
    ch_data    = '0;
    rst        = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_miso", 40'(spi_i.miso), 40'd0);
    check("rst_oe", 40'(spi_i.miso_oe), 40'd0);
    check("rst_valid", 40'(conv_valid), 40'd0);
    check("rst_sgl", 40'(conv_sgl), 40'd0);
    check("rst_ch", 40'(conv_ch), 40'd0);
    check("rst_result", 40'(conv_result), 40'd0);
    check("rst_abort", 40'(abort_cnt), 40'd0);

    // Single-ended read of CH3 = 0x2A5
    set_ch(3, 10'h2A5);
    v0 = valid_cnt;
    cs_low();
    xfer_byte(8'h01, rx1, oe1);
    xfer_byte(8'hB0, rx2, oe2);
    xfer_byte(8'h00, rx3, oe3);
    cs_high();
    check("se_valid_once", 40'(valid_cnt - v0), 40'd1);
    check("se_sgl", 40'(conv_sgl), 40'd1);
    check("se_ch", 40'(conv_ch), 40'd3);
    check("se_result", 40'(conv_result), 40'h2A5);
    check("se_byte2_low", 40'(rx2[1:0]), 40'h2);
    check("se_null_bit", 40'(rx2[2]), 40'd0);
    check("se_byte3", 40'(rx3), 40'hA5);
    check("se_oe_byte2", 40'(oe2), 40'h07);
    check("se_oe_byte3", 40'(oe3), 40'hFF);
    check("se_no_abort", 40'(abort_cnt), 40'd0);

    // Differential CH4(700) - CH5(200) = 500, then swapped pair clamps to 0
    set_ch(4, 10'd700);
    set_ch(5, 10'd200);
    cs_low();
    xfer_byte(8'h01, rx1, oe1);
    xfer_byte(8'h40, rx2, oe2);
    xfer_byte(8'h00, rx3, oe3);
    cs_high();
    check("diff_result", 40'(conv_result), 40'd500);
    check("diff_sgl", 40'(conv_sgl), 40'd0);
    check("diff_rx", 40'({rx2[1:0], rx3}), 40'd500);
    cs_low();
    xfer_byte(8'h01, rx1, oe1);
    xfer_byte(8'h50, rx2, oe2);
    xfer_byte(8'h00, rx3, oe3);
    cs_high();
    check("diff_swap_result", 40'(conv_result), 40'd0);
    check("diff_swap_ch", 40'(conv_ch), 40'd5);
    check("diff_swap_rx", 40'({rx2[1:0], rx3}), 40'd0);

    // Seven leading zeros, CH0 = 0x155, 40 clocks covering data, LSB tail and zeros
    set_ch(0, 10'h155);
    cs_low();
    xfer_byte(8'h01, rx1, oe1);
    xfer_byte(8'h80, rx2, oe2);
    xfer_byte(8'h00, rx3, oe3);
    xfer_byte(8'h00, rx4, oe4);
    xfer_byte(8'h00, rx5, oe5);
    cs_high();
    check("tail_rx", {rx1, rx2, rx3, rx4, rx5}, 40'h00_01_55_55_00);
    check("tail_oe", {oe1, oe2, oe3, oe4, oe5}, 40'h00_07_FF_FF_FF);
    check("tail_no_abort", 40'(abort_cnt), 40'd0);

    // CH1 = 0x3FF latched, cleared during DATA_MSB
    set_ch(1, 10'h3FF);
    cs_low();
    xfer_byte(8'h01, rx1, oe1);
    xfer_byte(8'h90, rx2, oe2);
    set_ch(1, 10'h000);
    xfer_byte(8'h00, rx3, oe3);
    cs_high();
    check("hold_rx", 40'({rx2[1:0], rx3}), 40'h3FF);
    check("hold_result", 40'(conv_result), 40'h3FF);

    // Reset pulse during DATA_MSB
    cs_low();
    xfer_byte(8'h01, rx1, oe1);
    xfer_byte(8'h80, rx2, oe2);
    check("mrst_pre_oe", 40'(spi_i.miso_oe), 40'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_outputs", {spi_i.miso, spi_i.miso_oe, conv_valid, conv_sgl, conv_ch, conv_result, abort_cnt},
          40'd0);
    rst = 1'b0;
    cs_high();
    check("mrst_no_abort", 40'(abort_cnt), 40'd0);
    set_ch(5, 10'h0F3);
    cs_low();
    xfer_byte(8'h01, rx1, oe1);
    xfer_byte(8'hD0, rx2, oe2);
    xfer_byte(8'h00, rx3, oe3);
    cs_high();
    check("mrst_next_rx", 40'({rx2[1:0], rx3}), 40'h0F3);
    check("mrst_next_ch", 40'(conv_ch), 40'd5);

    // Abort after D2: no conversion, counter steps to 1
    v0 = valid_cnt;
    cs_low();
    spi_bit(1'b1, mi, oe);
    spi_bit(1'b1, mi, oe);
    spi_bit(1'b0, mi, oe);
    spi_i.cs_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    check("abort1_oe", 40'(spi_i.miso_oe), 40'd0);
    check("abort1_cnt", 40'(abort_cnt), 40'd1);
    check("abort1_no_valid", 40'(valid_cnt - v0), 40'd0);
    repeat (10) @(negedge clk);

    // Abort while driving data: miso_oe must drop within SYNC_STAGES+2 clks
    cs_low();
    xfer_byte(8'h01, rx1, oe1);
    xfer_byte(8'h80, rx2, oe2);
    check("abort2_pre_oe", 40'(spi_i.miso_oe), 40'd1);
    spi_i.cs_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    check("abort2_oe", 40'(spi_i.miso_oe), 40'd0);
    check("abort2_miso", 40'(spi_i.miso), 40'd0);
    check("abort2_cnt", 40'(abort_cnt), 40'd2);
    repeat (10) @(negedge clk);

    // cs_n rise while still waiting for a start bit is not an abort
    cs_low();
    spi_bit(1'b0, mi, oe);
    spi_bit(1'b0, mi, oe);
    cs_high();
    check("wait_start_no_abort", 40'(abort_cnt), 40'd2);

    // 300 further aborts saturate the counter
    for (int n = 0; n < 300; n++) begin
      cs_low();
      spi_bit(1'b1, mi, oe);
      spi_bit(1'b1, mi, oe);
      spi_i.cs_n = 1'b1;
      repeat (6) @(negedge clk);
    end
    check("abort_saturate", 40'(abort_cnt), 40'd255);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
